sd_digit_packer: RTL and testbench

//  - Collects the signed digits produced one per cycle by the BKM iteration stage, MSD first.
//  - Packs each group of W digits into one 2W-bit CSD word.
//  - Hands that word to the combinational csd2bin converter through a valid/ready handshake.
//  - Sits between the BKM digit-recurrence datapath and csd2bin in xfire_fpu_bkm.

---
 rtl/sd_digit_packer_pkg.sv | 14 +
 rtl/sd_digit_sanitize.sv | 20 ++
 rtl/sd_digit_packer.sv | 107 ++++++++++
 tb/tb_sd_digit_packer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_digit_packer_pkg.sv
// Shared signed-digit codes and packer FSM states, used by the packer and its sanitizer.
package sd_digit_packer_pkg;

  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ILL  = 2'b11;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/sd_digit_sanitize.sv
// Combinational illegal signed-digit detector: flags code 11 and substitutes a zero digit.
module sd_digit_sanitize
  import sd_digit_packer_pkg::*;
(
  input  logic [1:0] i_digit,
  output logic [1:0] o_digit,
  output logic       o_illegal
);

  always_comb begin
    o_digit   = SD_ZERO;
    o_illegal = 1'b0;
    case (i_digit)
      SD_POS, SD_NEG: o_digit   = i_digit;
      SD_ILL:         o_illegal = 1'b1;
      default:        o_digit   = SD_ZERO;
    endcase
  end

endmodule

// File: rtl/sd_digit_packer.sv
// Packs W MSD-first signed digits into one 2W-bit CSD word behind a valid/ready handshake.
// Optional illegal-digit checking is enabled by defining SD_PACK_ERRCHK_EN.
module sd_digit_packer
  import sd_digit_packer_pkg::*;
#(
  parameter int W  = 73,
  parameter int CW = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           abort,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_digit,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_x_csd,
  output logic           err
);

  state_t         r_state, w_state_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic [2*W-1:0] r_shreg, w_shreg_next;
  logic           r_live;
  logic           w_accept;
  logic [1:0]     w_digit;

  // r_live keeps in_ready low while in reset and for the first cycle out of it
  assign in_ready  = r_live && (r_state == ST_COLLECT);
  assign out_valid = (r_state == ST_HOLD);
  assign out_x_csd = r_shreg;
  assign w_accept  = in_valid && in_ready;

`ifdef SD_PACK_ERRCHK_EN
  logic w_illegal;
  logic r_err;

  sd_digit_sanitize u_sanitize (
    .i_digit   (in_digit),
    .o_digit   (w_digit),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal && !abort) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_digit = in_digit;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_COLLECT;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shreg <= w_shreg_next;
      r_live  <= 1'b1;
    end
  end

  // abort takes priority over both a digit accept and an output handshake
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shreg_next = r_shreg;
    if (abort) begin
      w_state_next = ST_COLLECT;
      w_cnt_next   = '0;
      w_shreg_next = '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            w_shreg_next = {r_shreg[2*W-3:0], w_digit};
            if (r_cnt == CW'(W - 1)) begin
              w_state_next = ST_HOLD;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            w_state_next = ST_COLLECT;
            w_shreg_next = '0;
          end
        end
        default: begin
          w_state_next = ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_digit_packer.sv
// Self-checking bench: directed table and corner sequences on a W=4 packer, random words on W=73.
module tb_sd_digit_packer;

  localparam int WS     = 4;
  localparam int WL     = 73;
  localparam int NWORDS = 500;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            abort4, in_valid4, in_ready4, out_valid4, out_ready4, err4;
  logic [1:0]      in_digit4;
  logic [2*WS-1:0] out_x4;

  logic            abort73, in_valid73, in_ready73, out_valid73, out_ready73, err73;
  logic [1:0]      in_digit73;
  logic [2*WL-1:0] out_x73;

  sd_digit_packer #(.W(WS), .CW(3)) dut4 (
    .clk(clk), .rst(rst), .abort(abort4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_digit(in_digit4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_x_csd(out_x4), .err(err4)
  );

  sd_digit_packer #(.W(WL), .CW(7)) dut73 (
    .clk(clk), .rst(rst), .abort(abort73), .in_valid(in_valid73), .in_ready(in_ready73),
    .in_digit(in_digit73), .out_valid(out_valid73), .out_ready(out_ready73),
    .out_x_csd(out_x73), .err(err73)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] digs;      // MSD first in [7:6]
    logic [7:0] exp_word;
    int         exp_val;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [2*WL-1:0] act, input logic [2*WL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // numeric value of a W=4 CSD word: sum of +/-2^i over nonzero digits
  function automatic int csd_val4(input logic [7:0] w);
    int v = 0;
    for (int i = 0; i < 4; i++) begin
      if (w[2*i +: 2] == 2'b10) v += (1 << i);
      else if (w[2*i +: 2] == 2'b01) v -= (1 << i);
    end
    return v;
  endfunction

  // present one digit (optionally with abort) until the W=4 packer takes it; returns at the next negedge
  task automatic push4(input logic [1:0] d, input logic ab);
    int n = 0;
    in_valid4 = 1'b1;
    in_digit4 = d;
    abort4    = ab;
    while (!in_ready4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready4) begin
      total++;
      bad++;
      $display("FAIL push_timeout: in_ready got 0 expected 1");
    end
    @(negedge clk);
    in_valid4 = 1'b0;
    abort4    = 1'b0;
  endtask

  task automatic send_word4(input logic [7:0] digs);
    for (int i = 0; i < 4; i++) push4(digs[7-2*i -: 2], 1'b0);
  endtask

  task automatic handshake4();
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  initial begin
    logic [2*WL-1:0] cur;
    logic [2*WL-1:0] q[$];
    logic [1:0]      d;
    int              k, got, cyc;

    vecs[0] = '{8'b10_00_01_10, 8'h86,   7};
    vecs[1] = '{8'b01_01_01_01, 8'h55, -15};
    vecs[2] = '{8'b10_10_10_10, 8'hAA,  15};
    vecs[3] = '{8'b00_00_00_00, 8'h00,   0};
    vecs[4] = '{8'b10_01_10_01, 8'h99,   5};
    vecs[5] = '{8'b01_10_00_10, 8'h62,  -3};

    rst = 1'b1;
    abort4 = 1'b0; in_valid4 = 1'b0; in_digit4 = 2'b00; out_ready4 = 1'b0;
    abort73 = 1'b0; in_valid73 = 1'b0; in_digit73 = 2'b00; out_ready73 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_ready4", 146'(in_ready4), 146'(0));
    check("rst_out_valid4", 146'(out_valid4), 146'(0));
    check("rst_out_x4", 146'(out_x4), 146'(0));
    check("rst_err4", 146'(err4), 146'(0));
    check("rst_in_ready73", 146'(in_ready73), 146'(0));
    check("rst_out_x73", out_x73, 146'(0));

    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 146'(in_ready4), 146'(1));

    // table-driven words with immediate handshake
    for (int v = 0; v < 6; v++) begin
      send_word4(vecs[v].digs);
      check($sformatf("vec%0d_out_valid", v), 146'(out_valid4), 146'(1));
      check($sformatf("vec%0d_in_ready", v), 146'(in_ready4), 146'(0));
      check($sformatf("vec%0d_word", v), 146'(out_x4), 146'(vecs[v].exp_word));
      check_int($sformatf("vec%0d_value", v), csd_val4(out_x4), vecs[v].exp_val);
      handshake4();
      check($sformatf("vec%0d_drop_valid", v), 146'(out_valid4), 146'(0));
      check($sformatf("vec%0d_cleared", v), 146'(out_x4), 146'(0));
    end

    // back-pressure: word held for three cycles, next digit taken the cycle after handshake
    send_word4(8'h86);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 146'(out_valid4), 146'(1));
      check("hold_word", 146'(out_x4), 146'(8'h86));
      check("hold_in_ready", 146'(in_ready4), 146'(0));
    end
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    in_digit4  = 2'b10;
    @(negedge clk);
    out_ready4 = 1'b0;
    check("hs_no_early_accept", 146'(out_x4), 146'(0));
    @(negedge clk);
    in_valid4 = 1'b0;
    check("hs_next_digit_taken", 146'(out_x4), 146'(8'h02));
    push4(2'b00, 1'b0); push4(2'b00, 1'b0); push4(2'b00, 1'b0);
    check("hs_next_word", 146'(out_x4), 146'(8'h80));
    handshake4();

    // abort after two digits, then a full word of -1s
    push4(2'b10, 1'b0); push4(2'b10, 1'b0);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check("abort_flush", 146'(out_x4), 146'(0));
    send_word4(8'h55);
    check("abort_word", 146'(out_x4), 146'(8'h55));
    check_int("abort_value", csd_val4(out_x4), -15);
    handshake4();

    // abort with the 4th accept: no word, counter restarts
    push4(2'b10, 1'b0); push4(2'b10, 1'b0); push4(2'b10, 1'b0);
    push4(2'b01, 1'b1);
    check("abort4th_no_valid", 146'(out_valid4), 146'(0));
    check("abort4th_flush", 146'(out_x4), 146'(0));
    send_word4(8'h86);
    check("abort4th_restart_valid", 146'(out_valid4), 146'(1));
    check("abort4th_restart_word", 146'(out_x4), 146'(8'h86));
    // abort in HOLD together with out_ready: word lost
    abort4 = 1'b1;
    out_ready4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    out_ready4 = 1'b0;
    check("abort_hold_valid", 146'(out_valid4), 146'(0));
    check("abort_hold_flush", 146'(out_x4), 146'(0));
    repeat (2) @(negedge clk);
    check("abort_hold_stays_idle", 146'(out_valid4), 146'(0));
    send_word4(8'h99);
    check("abort_hold_next_word", 146'(out_x4), 146'(8'h99));
    handshake4();

    // illegal digit in the second slot
    send_word4(8'b10_11_00_01);
`ifdef SD_PACK_ERRCHK_EN
    check("ill_word", 146'(out_x4), 146'(8'h81));
    check("ill_err", 146'(err4), 146'(1));
`else
    check("ill_word", 146'(out_x4), 146'(8'hB1));
    check("ill_err", 146'(err4), 146'(0));
`endif
    handshake4();
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
`ifdef SD_PACK_ERRCHK_EN
    check("ill_err_after_abort", 146'(err4), 146'(1));
`else
    check("ill_err_after_abort", 146'(err4), 146'(0));
`endif

    // rst mid-word flushes the partial word and clears err
    push4(2'b10, 1'b0); push4(2'b01, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_err", 146'(err4), 146'(0));
    check("rst_mid_flush", 146'(out_x4), 146'(0));
    check("rst_mid_in_ready", 146'(in_ready4), 146'(0));
    send_word4(8'h62);
    check("rst_mid_word", 146'(out_x4), 146'(8'h62));
    handshake4();

    // random legal words on the W=73 instance against a positional model
    cur = '0;
    k   = 0;
    got = 0;
    cyc = 0;
    while (got < NWORDS && cyc < 60000) begin
      in_valid73  = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 2))
        0:       d = 2'b00;
        1:       d = 2'b10;
        default: d = 2'b01;
      endcase
      in_digit73  = d;
      out_ready73 = ($urandom_range(0, 3) != 0);
      if (in_valid73 && in_ready73) begin
        cur[2*(WL-1-k) +: 2] = d;
        k++;
        if (k == WL) begin
          q.push_back(cur);
          cur = '0;
          k   = 0;
        end
      end
      if (out_valid73 && out_ready73) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rand_extra_word: got %h expected no word", out_x73);
        end else begin
          check($sformatf("rand_word%0d", got), out_x73, q.pop_front());
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid73  = 1'b0;
    out_ready73 = 1'b0;
    check_int("rand_word_count", got, NWORDS);
    check("rand_err73", 146'(err73), 146'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
